// File: rtl/sfp_pkg.sv
// Shared widths, FSM state and SFP word layout for the block-floating-point aligner.
package sfp_pkg;
    localparam int EXP_W   = 4;
    localparam int SIG_W   = 4;
    localparam int LOW_EXP = 2;
    localparam int FMT_W   = 1 + EXP_W + SIG_W;
    localparam int FIX_W   = SIG_W + 4 + LOW_EXP;
    localparam int BLOCK_N = 8;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } sfp_t;
endpackage

// File: rtl/sfp2fix.sv
// Aligns one SFP word to the block exponent as a two's-complement fixed-point value;
// inverse of the fixed-to-SFP normaliser that follows the adder tree.
module sfp2fix
    import sfp_pkg::*;
#(
    parameter int expWidth    = EXP_W,
    parameter int sigWidth    = SIG_W,
    parameter int low_expand  = LOW_EXP,
    parameter int formatWidth = 1 + expWidth + sigWidth,
    parameter int FW          = sigWidth + 4 + low_expand
) (
    input  logic [formatWidth-1:0] in_sfp,
    input  logic [expWidth-1:0]    max_exp,
    output logic [FW-1:0]          fix
);
    localparam int MAG_W = sigWidth + 1 + low_expand;

    logic                sign_s;
    logic [expWidth-1:0] exp_s;
    logic [expWidth-1:0] shift_s;
    logic [sigWidth-1:0] sig_s;
    logic [MAG_W-1:0]    mag_s;
    logic [FW-1:0]       mag_fw_s;

    assign sign_s   = in_sfp[formatWidth-1];
    assign exp_s    = in_sfp[formatWidth-2 -: expWidth];
    assign sig_s    = in_sfp[sigWidth-1:0];
    assign shift_s  = max_exp - exp_s;
    // Shifts past the mantissa width fall out of the vector and truncate to zero.
    assign mag_s    = {1'b1, sig_s, {low_expand{1'b0}}} >> shift_s;
    assign mag_fw_s = {{(FW-MAG_W){1'b0}}, mag_s};

    // Zero exponent encodes zero; otherwise apply the sign (negating 0 yields 0).
    always_comb begin
        fix = {FW{1'b0}};
        if (exp_s == {expWidth{1'b0}}) begin
            fix = {FW{1'b0}};
        end else if (sign_s) begin
            fix = {FW{1'b0}} - mag_fw_s;
        end else begin
            fix = mag_fw_s;
        end
    end
endmodule

// File: rtl/sfp_block_align.sv
// Collects a block of SFP words, tracks the largest exponent, then emits each word
// aligned to that exponent together with the exponent itself.
module sfp_block_align
    import sfp_pkg::*;
#(
    parameter int expWidth    = EXP_W,
    parameter int sigWidth    = SIG_W,
    parameter int low_expand  = LOW_EXP,
    parameter int formatWidth = 1 + expWidth + sigWidth,
    parameter int BLOCK       = BLOCK_N,
    parameter int FW          = sigWidth + 4 + low_expand
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [formatWidth-1:0] in_sfp,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FW-1:0]          out_fix,
    output logic [expWidth-1:0]    out_max_exp,
    output logic                   out_last
);
    localparam int               IDX_W    = $clog2(BLOCK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK - 1);
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
    logic [expWidth-1:0]    max_q, max_d;
    logic [formatWidth-1:0] buf_q [BLOCK];
    logic [formatWidth-1:0] buf_d [BLOCK];
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [FW-1:0]          out_fix_q, out_fix_d;
    logic [expWidth-1:0]    out_max_exp_q, out_max_exp_d;

    logic                   in_hs_s;
    logic                   out_hs_s;
    logic [expWidth-1:0]    in_exp_s;
    logic [expWidth-1:0]    max_next_s;
    logic [IDX_W-1:0]       rd_next_s;
    logic [formatWidth-1:0] align_sfp_s;
    logic [expWidth-1:0]    align_max_s;
    logic [FW-1:0]          align_fix_s;

    assign in_ready    = in_ready_q & ~rst;
    assign out_valid   = out_valid_q;
    assign out_fix     = out_fix_q;
    assign out_max_exp = out_max_exp_q;
    assign out_last    = out_last_q;

    assign in_hs_s    = in_valid & in_ready_q & (state_q == FILL);
    assign out_hs_s   = out_valid_q & out_ready;
    assign in_exp_s   = in_sfp[formatWidth-2 -: expWidth];
    assign max_next_s = ((wr_idx_q == ZERO_IDX) || (in_exp_s > max_q)) ? in_exp_s : max_q;
    assign rd_next_s  = rd_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};

    // Word 0 is pre-aligned against the final maximum on the last fill edge so it is
    // valid right after that edge; in EMIT the next word is pre-aligned instead.
    assign align_sfp_s = (state_q == FILL) ? buf_q[0] : buf_q[rd_next_s];
    assign align_max_s = (state_q == FILL) ? max_next_s : max_q;

    sfp2fix #(
        .expWidth   (expWidth),
        .sigWidth   (sigWidth),
        .low_expand (low_expand),
        .formatWidth(formatWidth),
        .FW         (FW)
    ) u_sfp2fix (
        .in_sfp (align_sfp_s),
        .max_exp(align_max_s),
        .fix    (align_fix_s)
    );

    // Next-state logic for the fill/emit sequencer and its registered outputs.
    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        max_d         = max_q;
        buf_d         = buf_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_fix_d     = out_fix_q;
        out_max_exp_d = out_max_exp_q;
        case (state_q)
            FILL: begin
                if (in_hs_s) begin
                    buf_d[wr_idx_q] = in_sfp;
                    max_d           = max_next_s;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d      = ZERO_IDX;
                        state_d       = EMIT;
                        in_ready_d    = 1'b0;
                        out_valid_d   = 1'b1;
                        out_last_d    = 1'b0;
                        out_fix_d     = align_fix_s;
                        out_max_exp_d = max_next_s;
                    end else begin
                        wr_idx_d = wr_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    wr_idx_d = wr_idx_q;
                end
            end
            EMIT: begin
                if (out_hs_s) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d    = ZERO_IDX;
                        state_d     = FILL;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        rd_idx_d   = rd_next_s;
                        out_fix_d  = align_fix_s;
                        out_last_d = (rd_next_s == LAST_IDX);
                    end
                end else begin
                    rd_idx_d = rd_idx_q;
                end
            end
            default: begin
                state_d     = FILL;
                wr_idx_d    = ZERO_IDX;
                rd_idx_d    = ZERO_IDX;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // Control state and output registers; reset discards any partial block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FILL;
            wr_idx_q      <= ZERO_IDX;
            rd_idx_q      <= ZERO_IDX;
            max_q         <= {expWidth{1'b0}};
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_fix_q     <= {FW{1'b0}};
            out_max_exp_q <= {expWidth{1'b0}};
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            max_q         <= max_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_fix_q     <= out_fix_d;
            out_max_exp_q <= out_max_exp_d;
        end
    end

    // Block storage has no reset; its contents are rewritten by every fill.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end
endmodule

// File: tb/tb_sfp_block_align.sv
// Directed and randomized checks of sfp_block_align against an arithmetic reference model.
module tb_sfp_block_align;
    import sfp_pkg::*;

    localparam int FW = FIX_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [FMT_W-1:0] in_sfp = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [FW-1:0]    out_fix;
    logic [EXP_W-1:0] out_max_exp;
    logic             out_last;

    int checks = 0;
    int errors = 0;
    logic [FMT_W-1:0] blk [BLOCK_N];

    always #5 clk = ~clk;

    sfp_block_align dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sfp     (in_sfp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_fix    (out_fix),
        .out_max_exp(out_max_exp),
        .out_last   (out_last)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Largest exponent of the block; zero-exponent words contribute 0.
    function automatic int ref_max();
        int m = 0;
        sfp_t w;
        for (int i = 0; i < BLOCK_N; i++) begin
            w = blk[i];
            if (int'(w.exp) > m) m = int'(w.exp);
        end
        return m;
    endfunction

    // Value = (1.sig * 2^low_expand) / 2^(max-e), truncated, signed, as FW-bit pattern.
    function automatic logic [FW-1:0] ref_fix(input logic [FMT_W-1:0] word, input int mx);
        sfp_t w;
        int mag;
        int v;
        logic [31:0] bits;
        w = word;
        if (w.exp == 4'd0) return '0;
        mag = ((1 << SIG_W) + int'(w.sig)) * (1 << LOW_EXP);
        mag = mag / (2 ** (mx - int'(w.exp)));
        v = w.sign ? -mag : mag;
        bits = v;
        return bits[FW-1:0];
    endfunction

    function automatic logic [FMT_W-1:0] rand_word(input int max_e);
        sfp_t w;
        w.sign = 1'($urandom_range(0, 1));
        w.exp  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, max_e));
        w.sig  = 4'($urandom_range(0, 15));
        return w;
    endfunction

    task automatic fill_block(input bit gaps);
        int i = 0;
        int cyc = 0;
        while (i < BLOCK_N) begin
            @(negedge clk);
            cyc++;
            if (cyc > 200) begin
                checks++; errors++;
                $error("FAIL fill_timeout: observed %0d words expected %0d", i, BLOCK_N);
                in_valid = 1'b0;
                return;
            end
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_sfp   = blk[i];
            if (in_valid && in_ready) i++;
        end
    endtask

    task automatic drain_block(input bit rnd_ready, input int stall_at, input int stall_len,
                               input bit keep_valid, input int rst_at);
        int k = 0;
        int stall = 0;
        int cyc = 0;
        int mx;
        int v;
        logic [FW-1:0] f;
        sfp_t rt;
        mx = ref_max();
        while (k < BLOCK_N) begin
            @(negedge clk);
            cyc++;
            if (cyc > 400) begin
                checks++; errors++;
                $error("FAIL drain_timeout: observed %0d words expected %0d", k, BLOCK_N);
                return;
            end
            in_valid = keep_valid;
            in_sfp   = FMT_W'($urandom);
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_out_valid", 16'(out_valid), 16'd0);
                chk("rst_in_ready", 16'(in_ready), 16'd0);
                chk("rst_out_last", 16'(out_last), 16'd0);
                @(negedge clk);
                rst = 1'b0;
                in_valid = 1'b0;
                out_ready = 1'b0;
                #1;
                chk("post_rst_in_ready", 16'(in_ready), 16'd1);
                return;
            end
            chk("out_valid", 16'(out_valid), 16'd1);
            chk("in_ready_emit", 16'(in_ready), 16'd0);
            chk("out_fix", 16'(out_fix), 16'(ref_fix(blk[k], mx)));
            chk("out_max_exp", 16'(out_max_exp), 16'(mx));
            chk("out_last", 16'(out_last), 16'(k == BLOCK_N - 1));
            if (int'(blk[k][7:4]) == mx && mx != 0) begin
                f = out_fix;
                v = f[FW-1] ? int'(f) - (1 << FW) : int'(f);
                if (v < 0) v = -v;
                rt.sign = f[FW-1];
                rt.exp  = 4'(mx);
                rt.sig  = 4'((v >> LOW_EXP) & 15);
                chk("roundtrip", 16'(rt), 16'(blk[k]));
            end
            if (k == stall_at && stall < stall_len) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (out_ready) k++;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("in_ready_after", 16'(in_ready), 16'd1);
        chk("out_valid_after", 16'(out_valid), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 16'(out_valid), 16'd0);
        chk("reset_out_last", 16'(out_last), 16'd0);
        chk("reset_out_fix", 16'(out_fix), 16'd0);
        chk("reset_out_max_exp", 16'(out_max_exp), 16'd0);
        chk("reset_in_ready", 16'(in_ready), 16'd0);
        rst = 1'b0;
        #1;
        chk("release_in_ready", 16'(in_ready), 16'd1);

        // Uniform block: every word aligns to 10'h040.
        for (int i = 0; i < BLOCK_N; i++) blk[i] = 9'b0_0101_0000;
        fill_block(1'b0);
        drain_block(1'b0, -1, 0, 1'b0, -1);

        // Mixed exponents including a negative word and a 6-bit shift.
        blk[0] = 9'b0_0111_1000;
        blk[1] = 9'b1_0101_0000;
        for (int i = 2; i < BLOCK_N; i++) blk[i] = 9'b0_0001_0000;
        fill_block(1'b0);
        drain_block(1'b0, -1, 0, 1'b0, -1);

        // Zero-exponent words with nonzero sign/significand.
        blk[0] = 9'b0_0111_0011;
        blk[1] = 9'b0_0000_1111;
        blk[2] = 9'b1_0000_0101;
        for (int i = 3; i < BLOCK_N; i++) blk[i] = rand_word(7);
        fill_block(1'b0);
        drain_block(1'b0, -1, 0, 1'b0, -1);

        // All-zero block.
        for (int i = 0; i < BLOCK_N; i++) blk[i] = {1'($urandom_range(0, 1)), 4'd0, 4'($urandom_range(0, 15))};
        fill_block(1'b0);
        drain_block(1'b0, -1, 0, 1'b0, -1);

        // Backpressure at word 3 with in_valid held high through EMIT.
        for (int i = 0; i < BLOCK_N; i++) blk[i] = rand_word(15);
        fill_block(1'b0);
        drain_block(1'b0, 3, 3, 1'b1, -1);

        // Reset during EMIT, then a fresh block.
        for (int i = 0; i < BLOCK_N; i++) blk[i] = rand_word(15);
        fill_block(1'b0);
        drain_block(1'b0, -1, 0, 1'b0, 5);
        for (int i = 0; i < BLOCK_N; i++) blk[i] = rand_word(15);
        fill_block(1'b0);
        drain_block(1'b0, -1, 0, 1'b0, -1);

        // Randomized sweep with input gaps and output backpressure.
        for (int b = 0; b < 24; b++) begin
            for (int i = 0; i < BLOCK_N; i++) blk[i] = rand_word(15);
            if (b % 3 == 0) blk[$urandom_range(0, BLOCK_N - 1)] = {1'($urandom_range(0, 1)), 4'd15, 4'($urandom_range(0, 15))};
            fill_block(1'b1);
            drain_block(1'b1, -1, 0, 1'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sfp_block_align.md
# sfp_block_align

Block-floating-point aligner for the Hadamard datapath. It converts a block of `BLOCK` SFP words (sign | exponent | significand, implicit leading one) into two's-complement fixed-point words aligned to the block's largest exponent, and forwards that exponent with the block. Its output format is exactly the `fixin`/`max_exp` pair consumed by the fixed-to-SFP normaliser after the adder tree, so a word whose exponent equals the block maximum round-trips bit-exact.

## Interface
- `expWidth`, 4, exponent field width
- `sigWidth`, 4, stored significand width (no hidden bit)
- `formatWidth`, 9, SFP word width = 1 + `expWidth` + `sigWidth`
- `low_expand`, 2, guard LSBs kept below the significand
- `BLOCK`, 8, words per block; power of two, ≥ 2
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `in_valid`  in  1  `in_sfp` is valid
- `in_ready`  out  1  block accepts a word
- `in_sfp`  in  `formatWidth`  {sign, exp, sig}
- `out_valid`  out  1  `out_fix` / `out_max_exp` / `out_last` valid
- `out_ready`  in  1  downstream accepts
- `out_fix`  out  `sigWidth+4+low_expand` (FW)  aligned two's-complement value
- `out_max_exp`  out  `expWidth`  block maximum exponent
- `out_last`  out  1  final word of the block

## Operation
- FSM with two states, FILL and EMIT. Reset state is FILL.
- **FILL:**
  - `in_ready` = 1.
  - On handshake, store `in_sfp` in `buf[wr_idx]` and increment `wr_idx`.
  - Update `max_r`: load e on `wr_idx`==0; otherwise `max_r` ← max(`max_r`, e).
  - An exponent field of 0 encodes zero. It contributes 0 to the max, and its sign and significand are ignored.
  - Accepting word `BLOCK-1` moves the FSM to EMIT and wraps `wr_idx` to 0.
- **EMIT:**
  - `in_ready` = 0 and `out_valid` = 1.
  - Present `buf[rd_idx]`, aligned; `out_last` = (`rd_idx` == `BLOCK-1`).
  - On an output handshake, increment `rd_idx`. The handshake on the last word moves the FSM to FILL and wraps `rd_idx` to 0.
- **Alignment** (per word, with e ≠ 0):
  - `mag` = {1, sig, `low_expand`'b0} >> (`max_r` − e), truncated with no rounding, zero-extended to FW.
  - At shift 0 the leading one sits at bit `sigWidth+low_expand`, leaving 3 headroom MSBs for the adder tree.
  - A shift ≥ `sigWidth+1+low_expand` gives `mag` = 0.
  - `out_fix` = sign ? −`mag` : `mag`. Result −0 is emitted as 0.
  - If e == 0, `out_fix` = 0.
- `out_max_exp` = `max_r`. An all-zero block gives `max_r` = 0.

## Timing
- Reset values:
  - `out_valid` = 0, `out_last` = 0, `out_fix` = 0, `out_max_exp` = 0.
  - `wr_idx` = `rd_idx` = 0; state FILL.
  - `in_ready` is forced 0 while `rst` is high and becomes 1 in the first cycle after deassertion.
- Latency: if the last input is accepted at edge T, word 0 is valid immediately after T, so the first output handshake can occur at T+1.
- Throughput: one word per cycle in each phase. The block is not double-buffered, so a full block takes 2·`BLOCK` cycles.
- Backpressure: while `out_valid` && !`out_ready`, every output holds stable.
- `in_ready` returns to 1 after the edge carrying the last output handshake.
- `in_valid` in EMIT is ignored, and no write occurs.
- `rst` asserted mid-block:
  - `out_valid` and `in_ready` drop immediately.
  - Any partial block is discarded.
  - Buffer contents are don't-care.

## Structure
- Shared package `sfp_pkg` holds:
  - default widths;
  - `FIX_W` = `sigWidth+4+low_expand`;
  - the state enum {FILL, EMIT};
  - an SFP field struct {sign, exp, sig}.
- One combinational sub-module, `sfp2fix`, maps (`in_sfp`, `max_exp`) to a FW-bit aligned value. It is the inverse of the fixed-to-SFP normaliser.
- The top level holds the FSM, the indices, `max_r` and the `BLOCK`-entry buffer.

## Test plan
1. Block of 8 × `0_0101_0000` → `out_max_exp` = 5; every `out_fix` = 10'h040; `out_last` only on word 7.
2. Block {`0_0111_1000`, `1_0101_0000`, 6 × `0_0001_0000`}:
   - `out_max_exp` = 7;
   - `out_fix` = 10'h060, 10'h3F0, then 6 × 10'h001.
3. A word with exp 7 plus words `0_0000_1111` and `1_0000_0101` → both zero-exp words give `out_fix` = 0. An all-zero block gives `out_max_exp` = 0 and all outputs 0.
4. Hold `out_ready` low for 3 cycles at word 3:
   - outputs stay stable and no word is skipped or duplicated;
   - `in_valid` held high throughout EMIT writes nothing;
   - `in_ready` rises after the word-7 handshake.
5. Assert `rst` at word 5 of EMIT → `out_valid` drops immediately. After release, a fresh block emits correctly with `rd_idx` restarting at 0.
6. Full-scale alignment sweep: random blocks checked against a reference model. Round-trip through the normaliser is exact for words with e == max.
